// File: rtl/bnn_out_pkg.sv
// rtl/bnn_out_pkg.sv - shared types and width helpers for the BNN output layer controller
package bnn_out_pkg;

    // IDLE and LOAD together form the input-accepting phase.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } ctrl_state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int cls_w(input int num_classes);
        return clog2_min1(num_classes);
    endfunction

    function automatic int waddr_w(input int num_classes, input int beats);
        return clog2_min1(num_classes * beats);
    endfunction

endpackage

// File: rtl/out_argmax.sv
// rtl/out_argmax.sv - streaming argmax register with lowest-index tie-break
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   clr              drop the held winner back to index 0 / score 0
//   in_valid         a new (index, score) pair is offered
//   in_first         the offered pair is the first of its sweep; taken unconditionally
//   in_idx, in_score candidate index and score
//   best_idx         index of the highest score seen so far
//   best_score       that score
module out_argmax
    import bnn_out_pkg::*;
#(
    parameter int IDX_W   = 4,
    parameter int SCORE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic [SCORE_W-1:0] in_score,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score
);

    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d;

    // Strictly-greater update means an equal later score never displaces
    // an earlier (lower) index.
    always_comb begin
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        if (clr) begin
            best_idx_d   = '0;
            best_score_d = '0;
        end else if (in_valid && (in_first || (in_score > best_score_q))) begin
            best_idx_d   = in_idx;
            best_score_d = in_score;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_idx_q   <= '0;
            best_score_q <= '0;
        end else begin
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
        end
    end

    assign best_idx   = best_idx_q;
    assign best_score = best_score_q;

endmodule

// File: rtl/output_layer_ctrl.sv
// rtl/output_layer_ctrl.sv - sequences the BNN output layer onto one shared neuron and picks the argmax class
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready/in_data        activation beats, beat 0 first
//   w_addr/w_data                    weight memory, address class*BEATS+beat, 1-cycle read latency
//   nrn_x/nrn_w/nrn_valid/nrn_last   beat stream into the shared neuron
//   nrn_valid_out/nrn_popcount       per-class popcount back from the neuron
//   out_valid/out_ready              result handshake
//   out_class/out_score              winning class and its popcount
module output_layer_ctrl
    import bnn_out_pkg::*;
#(
    parameter int PW          = 8,
    parameter int IN_BITS     = 256,
    parameter int NUM_CLASSES = 10,
    parameter int THRESH_W    = 16,
    localparam int BEATS      = IN_BITS / PW,
    localparam int WADDR_W    = waddr_w(NUM_CLASSES, BEATS),
    localparam int CLS_W      = cls_w(NUM_CLASSES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PW-1:0]       in_data,
    output logic [WADDR_W-1:0]  w_addr,
    input  logic [PW-1:0]       w_data,
    output logic [PW-1:0]       nrn_x,
    output logic [PW-1:0]       nrn_w,
    output logic                nrn_valid,
    output logic                nrn_last,
    input  logic                nrn_valid_out,
    input  logic [THRESH_W-1:0] nrn_popcount,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CLS_W-1:0]    out_class,
    output logic [THRESH_W-1:0] out_score
);

    localparam int BW    = clog2_min1(BEATS);
    localparam int TOTAL = NUM_CLASSES * BEATS;

    ctrl_state_t        state_q, state_d;
    logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]      run_beat_q, run_beat_d;
    logic [WADDR_W-1:0] w_addr_q, w_addr_d;
    logic [CLS_W-1:0]   result_idx_q, result_idx_d;
    logic [PW-1:0]      act_q [BEATS];
    logic [PW-1:0]      act_d [BEATS];
    logic               in_ready_q, in_ready_d;
    logic [PW-1:0]      nrn_x_q, nrn_x_d;
    logic               nrn_valid_q, nrn_valid_d;
    logic               nrn_last_q, nrn_last_d;
    logic               out_valid_q, out_valid_d;
    logic               am_clr;
    logic               accept;
    logic               res_take;

    assign accept   = in_valid && in_ready_q;
    // Popcounts only mean something while a sweep is in flight.
    assign res_take = nrn_valid_out && ((state_q == RUN) || (state_q == DRAIN));

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        run_beat_d   = run_beat_q;
        w_addr_d     = w_addr_q;
        result_idx_d = result_idx_q;
        act_d        = act_q;
        in_ready_d   = in_ready_q;
        nrn_x_d      = nrn_x_q;
        nrn_valid_d  = 1'b0;
        nrn_last_d   = 1'b0;
        out_valid_d  = out_valid_q;
        am_clr       = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                if (accept) begin
                    act_d[beat_cnt_q] = in_data;
                    if (beat_cnt_q == BW'(BEATS - 1)) begin
                        beat_cnt_d   = '0;
                        state_d      = RUN;
                        in_ready_d   = 1'b0;
                        result_idx_d = '0;
                        am_clr       = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        state_d    = LOAD;
                    end
                end
            end
            RUN: begin
                // w_data for this address arrives next cycle; the buffer beat
                // and last tag are registered so they land alongside it.
                nrn_valid_d = 1'b1;
                nrn_x_d     = act_q[run_beat_q];
                nrn_last_d  = (run_beat_q == BW'(BEATS - 1));
                if (w_addr_q == WADDR_W'(TOTAL - 1)) begin
                    w_addr_d   = '0;
                    run_beat_d = '0;
                    state_d    = DRAIN;
                end else begin
                    w_addr_d   = w_addr_q + 1'b1;
                    run_beat_d = (run_beat_q == BW'(BEATS - 1)) ? '0 : run_beat_q + 1'b1;
                end
            end
            DRAIN: begin
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (res_take) begin
            if (result_idx_q == CLS_W'(NUM_CLASSES - 1)) begin
                result_idx_d = '0;
                state_d      = DONE;
                out_valid_d  = 1'b1;
            end else begin
                result_idx_d = result_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            run_beat_q   <= '0;
            w_addr_q     <= '0;
            result_idx_q <= '0;
            for (int i = 0; i < BEATS; i++) act_q[i] <= '0;
            in_ready_q   <= 1'b1;
            nrn_x_q      <= '0;
            nrn_valid_q  <= 1'b0;
            nrn_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            run_beat_q   <= run_beat_d;
            w_addr_q     <= w_addr_d;
            result_idx_q <= result_idx_d;
            act_q        <= act_d;
            in_ready_q   <= in_ready_d;
            nrn_x_q      <= nrn_x_d;
            nrn_valid_q  <= nrn_valid_d;
            nrn_last_q   <= nrn_last_d;
            out_valid_q  <= out_valid_d;
        end
    end

    out_argmax #(
        .IDX_W   (CLS_W),
        .SCORE_W (THRESH_W)
    ) u_argmax (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (am_clr),
        .in_valid   (res_take),
        .in_first   (result_idx_q == '0),
        .in_idx     (result_idx_q),
        .in_score   (nrn_popcount),
        .best_idx   (out_class),
        .best_score (out_score)
    );

    assign in_ready  = in_ready_q;
    assign w_addr    = w_addr_q;
    assign nrn_x     = nrn_x_q;
    assign nrn_w     = w_data;
    assign nrn_valid = nrn_valid_q;
    assign nrn_last  = nrn_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_output_layer_ctrl.sv
// tb/tb_output_layer_ctrl.sv - self-checking bench for output_layer_ctrl (4 beats x 8 bits, 4 classes)
module tb_output_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic [3:0]  w_addr;
    logic [7:0]  w_data = '0;
    logic [7:0]  nrn_x, nrn_w;
    logic        nrn_valid, nrn_last;
    logic        nrn_valid_out = 1'b0;
    logic [15:0] nrn_popcount = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_class;
    logic [15:0] out_score;

    logic [7:0]  xv   [4];
    logic [7:0]  wmem [16];
    logic [15:0] acc = '0;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    output_layer_ctrl #(
        .PW(8), .IN_BITS(32), .NUM_CLASSES(4), .THRESH_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_addr(w_addr), .w_data(w_data),
        .nrn_x(nrn_x), .nrn_w(nrn_w), .nrn_valid(nrn_valid), .nrn_last(nrn_last),
        .nrn_valid_out(nrn_valid_out), .nrn_popcount(nrn_popcount),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_score(out_score)
    );

    // Weight memory with one cycle of read latency.
    always @(posedge clk) w_data <= wmem[w_addr];

    // Behavioural XNOR-popcount neuron, cleared on last, reset from !rst_n.
    always @(posedge clk) begin
        if (!rst_n) begin
            acc           <= '0;
            nrn_valid_out <= 1'b0;
            nrn_popcount  <= '0;
        end else begin
            nrn_valid_out <= 1'b0;
            if (nrn_valid) begin
                if (nrn_last) begin
                    nrn_popcount  <= acc + 16'($countones(~(nrn_x ^ nrn_w)));
                    nrn_valid_out <= 1'b1;
                    acc           <= '0;
                end else begin
                    acc <= acc + 16'($countones(~(nrn_x ^ nrn_w)));
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: score every class directly, keep the first maximum.
    task automatic model(output int cls, output int score);
        int pc;
        cls = 0;
        score = -1;
        for (int c = 0; c < 4; c++) begin
            pc = 0;
            for (int k = 0; k < 4; k++) pc += $countones(~(xv[k] ^ wmem[c*4+k]));
            if (pc > score) begin
                score = pc;
                cls = c;
            end
        end
    endtask

    // Feeds xv[0..3] following the valid pattern (valid=1 beyond vlen);
    // returns at the negedge of the first RUN cycle.
    task automatic load(input string tag, input logic [15:0] vpat, input int vlen);
        int acc_n;
        int i;
        acc_n = 0;
        i = 0;
        while (acc_n < 4 && i < 100) begin
            in_valid = (i < vlen) ? vpat[i] : 1'b1;
            in_data  = in_valid ? xv[acc_n] : 8'h3C;
            if (in_valid && in_ready) acc_n++;
            @(negedge clk);
            i++;
        end
        in_valid = 1'b0;
        chk({tag, "_load_beats"}, acc_n, 4);
    endtask

    task automatic finish_run(input string tag, input int exp_cls, input int exp_score, input int hold);
        int lat;
        // Stray input during RUN/DRAIN/DONE must not disturb the buffer.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        for (int n = 0; n <= 16; n++) begin
            if (n < 16) chk({tag, "_w_addr"}, w_addr, n);
            if (n == 0) begin
                chk({tag, "_nrn_valid_t0"}, nrn_valid, 0);
                chk({tag, "_in_ready_t0"}, in_ready, 0);
            end else begin
                chk({tag, "_nrn_valid"}, nrn_valid, 1);
                chk({tag, "_nrn_x"}, nrn_x, xv[(n-1) % 4]);
                chk({tag, "_nrn_w"}, nrn_w, wmem[n-1]);
                chk({tag, "_nrn_last"}, nrn_last, ((n-1) % 4) == 3);
            end
            @(negedge clk);
        end
        chk({tag, "_nrn_valid_drain"}, nrn_valid, 0);
        lat = 17;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_out_latency"}, lat, 18);
        chk({tag, "_out_class"}, out_class, exp_cls);
        chk({tag, "_out_score"}, out_score, exp_score);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_class"}, out_class, exp_cls);
            chk({tag, "_hold_score"}, out_score, exp_score);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    task automatic set_basic();
        for (int k = 0; k < 4; k++) xv[k] = 8'hFF;
        for (int a = 0; a < 16; a++) wmem[a] = (a / 4 == 2) ? 8'hFF : 8'h00;
    endtask

    initial begin
        int ec, es, seen;
        logic [15:0] pat;

        for (int a = 0; a < 16; a++) wmem[a] = '0;
        for (int k = 0; k < 4; k++) xv[k] = '0;

        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_nrn_valid", nrn_valid, 0);
        chk("rst_nrn_last", nrn_last, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_score", out_score, 0);
        chk("rst_w_addr", w_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic inference: popcounts 0,0,32,0
        set_basic();
        load("basic", 16'h000F, 4);
        finish_run("basic", 2, 32, 0);

        // Tie between classes 1 and 3 at 20, with backpressure
        for (int k = 0; k < 4; k++) xv[k] = 8'hFF;
        wmem[0]  = 8'h1F; wmem[1]  = 8'h00; wmem[2]  = 8'h00; wmem[3]  = 8'h00;
        wmem[4]  = 8'hFF; wmem[5]  = 8'hFF; wmem[6]  = 8'h0F; wmem[7]  = 8'h00;
        wmem[8]  = 8'h7F; wmem[9]  = 8'h00; wmem[10] = 8'h00; wmem[11] = 8'h00;
        wmem[12] = 8'h0F; wmem[13] = 8'hFF; wmem[14] = 8'hFF; wmem[15] = 8'h00;
        load("tie", 16'h000F, 4);
        finish_run("tie", 1, 20, 5);

        // Independent random inference right after the handshake
        for (int k = 0; k < 4; k++) xv[k] = 8'($urandom);
        for (int a = 0; a < 16; a++) wmem[a] = 8'($urandom);
        model(ec, es);
        load("rand_a", 16'h000F, 4);
        finish_run("rand_a", ec, es, 0);

        // Input gaps 1,0,0,1,1,0,1
        for (int k = 0; k < 4; k++) xv[k] = 8'($urandom);
        for (int a = 0; a < 16; a++) wmem[a] = 8'($urandom);
        model(ec, es);
        load("gaps", 16'b1011001, 7);
        finish_run("gaps", ec, es, 2);

        // All popcounts zero -> class 0, score 0
        for (int k = 0; k < 4; k++) xv[k] = 8'($urandom);
        for (int a = 0; a < 16; a++) wmem[a] = ~xv[a % 4];
        load("zero", 16'h000F, 4);
        finish_run("zero", 0, 0, 0);

        // Reset mid-RUN at T0+6
        for (int k = 0; k < 4; k++) xv[k] = 8'($urandom);
        for (int a = 0; a < 16; a++) wmem[a] = 8'($urandom);
        load("abort", 16'h000F, 4);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_nrn_valid", nrn_valid, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_result", seen, 0);
        set_basic();
        load("after_abort", 16'h000F, 4);
        finish_run("after_abort", 2, 32, 0);

        // Random inferences with random valid gaps
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) xv[k] = 8'($urandom);
            for (int a = 0; a < 16; a++) wmem[a] = 8'($urandom);
            pat = 16'($urandom);
            model(ec, es);
            load("rand_gap", pat, 16);
            finish_run("rand_gap", ec, es, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/output_layer_ctrl.md
Name: output_layer_ctrl

Overview:
Sequences the final (output) layer of the BNN classifier onto one time-multiplexed output neuron. Buffers one binarized input vector, replays it once per class against that class's weights from the weight memory, and collects each class popcount. Tracks a running argmax and presents the winning class and its score over a valid/ready handshake.

Parameters:
PW, 8, bits per beat; must match the neuron's PW.
IN_BITS, 256, input vector width; must be a multiple of PW.
NUM_CLASSES, 10, number of output classes (>=2).
THRESH_W, 16, popcount width; must satisfy THRESH_W >= clog2(IN_BITS+1).
BEATS, IN_BITS/PW, derived localparam.
WADDR_W, clog2(NUM_CLASSES*BEATS), derived localparam.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  controller accepts an input beat
in_data  in  PW  input activation beat; beat 0 first
w_addr  out  WADDR_W  weight memory address = class*BEATS + beat
w_data  in  PW  weight word; 1-cycle read latency
nrn_x  out  PW  neuron activation beat
nrn_w  out  PW  neuron weight beat
nrn_valid  out  1  neuron beat valid
nrn_last  out  1  last beat of the current class
nrn_valid_out  in  1  neuron popcount valid
nrn_popcount  in  THRESH_W  neuron class popcount
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
out_class  out  clog2(NUM_CLASSES)  argmax class index
out_score  out  THRESH_W  popcount of the winning class

Behaviour:
- Reset: all logic clears on a clk edge with rst_n=0. After reset: state=IDLE, in_ready=1, nrn_valid=0, nrn_last=0, out_valid=0, out_class=0, out_score=0, w_addr=0, all counters=0. The neuron's reset is driven from !rst_n at the top level.
- States are IDLE, LOAD, RUN, DRAIN and DONE. IDLE and LOAD are a single accepting phase.
- IDLE/LOAD:
  - in_ready=1. Each in_valid&&in_ready stores in_data into activation buffer[beat_cnt] and increments beat_cnt.
  - in_valid gaps are allowed.
  - Acceptance of beat BEATS-1 moves the block to RUN on the next cycle and clears beat_cnt. in_ready=0 from that cycle.
- RUN:
  - Starts at cycle T0. One address is issued per cycle with no stalls: w_addr = c*BEATS + k at T0 + c*BEATS + k, with c in 0..NUM_CLASSES-1 and k in 0..BEATS-1.
  - The buffer read and the (c,k) tags are delayed one cycle to align with w_data. nrn_x, nrn_w and nrn_valid=1 appear at cycle +1. nrn_last=1 when k=BEATS-1.
  - Classes run back-to-back. The neuron clears its accumulator on last.
  - After the final address, move to DRAIN.
- DRAIN: wait for the result count to reach NUM_CLASSES. nrn_valid=0.
- Result collection:
  - Each nrn_valid_out increments result_idx.
  - The popcount is compared against best_score. Update on strictly greater, or unconditionally for result_idx=0. Ties therefore keep the lowest class index.
  - Comparison is unsigned at THRESH_W.
- DONE:
  - Entered after the last result registers. out_valid rises at T0 + NUM_CLASSES*BEATS + 2.
  - out_class and out_score hold stable while out_valid && !out_ready.
  - On out_valid&&out_ready: out_valid=0 and the block returns to IDLE next cycle (in_ready=1 next cycle). New input is never accepted while a result is pending.
- Boundary rules:
  - nrn_valid_out outside RUN/DRAIN is ignored.
  - If all popcounts are 0, output class 0 with score 0.
  - in_valid during RUN/DRAIN/DONE is ignored and no data is consumed.
  - Reset mid-RUN aborts immediately: nrn_valid=0 on the first cycle after the reset edge, and no partial result is emitted.

Decomposition:
- Package bnn_out_pkg holds:
  - state enum ctrl_state_t {IDLE, LOAD, RUN, DRAIN, DONE};
  - width helper functions for the class index and WADDR_W.
- Sub-module out_argmax: a streaming argmax register with clear, valid, index, score and lowest-index tie-break. It is instantiated once.
- Activation buffer: BEATS x PW registers kept inline.

Test Plan (PW=8, IN_BITS=32 so BEATS=4, NUM_CLASSES=4; behavioural neuron model):
- Reset: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, nrn_valid=0, out_class=0, out_score=0.
- Basic inference: input beats 0xFF x4; class 2 weights=0xFF, others 0x00 -> popcounts 0,0,32,0. Expect out_class=2, out_score=32, out_valid at T0+18, and w_addr sweeping 0..15 contiguously.
- Tie: weights give popcounts 5,20,7,20 -> out_class=1, out_score=20.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> outputs stable and in_ready=0. Then raise out_ready -> handshake, in_ready=1 next cycle; a second inference gives the correct independent result.
- Input gaps: in_valid pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; RUN starts the cycle after the 4th accept.
- Reset mid-RUN: assert rst_n=0 at T0+6 -> nrn_valid=0 next cycle, no out_valid. A full inference after reset matches the basic inference result.
